// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard controller.
//   fwd_sel_e  : operand mux select (none / writeback / memory)
//   md_state_e : mult/div tracker state
//   REG_ZERO   : architectural $0, never a hazard source
//   reg_match  : register compare that treats $0 as "no dependency"
//   fwd_select : M-over-W priority forwarding select for one operand
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $0 is hardwired, so a write to it or a read of it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

    // The younger producer (M) holds the newer value, so it wins over W.
    function automatic fwd_sel_e fwd_select(input logic       wr_m,
                                            input logic [4:0] dst_m,
                                            input logic       wr_w,
                                            input logic [4:0] dst_w,
                                            input logic [4:0] src);
        if (wr_m && reg_match(src, dst_m))
            return FWD_MEM;
        else if (wr_w && reg_match(src, dst_w))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// hazard_if: bundle between the datapath pipeline registers and the hazard unit.
//   Datapath -> hazard: decode/execute source regs, per-stage destination regs,
//                       write/load flags, branch and mult/div indications, PerfClr.
//   Hazard -> datapath: stall/flush controls, forwarding selects, MdBusy and
//                       performance counters.
//   modport master : datapath side
//   modport slave  : hazard unit side
interface hazard_if;
    logic [4:0]  RsD, RtD;
    logic [4:0]  RsE, RtE;
    logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        MemtoRegE, MemtoRegM;
    logic        BranchD;
    logic        MdUseD;
    logic        MdStartE, MdIsDivE;
    logic        PerfClr;

    logic        StallF, StallD, FlushE;
    logic        ForwardAD, ForwardBD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MdBusy;
    logic [31:0] StallCnt, LoadUseCnt;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, MdUseD, MdStartE, MdIsDivE, PerfClr,
        input  StallF, StallD, FlushE, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, MdBusy, StallCnt, LoadUseCnt
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, MdUseD, MdStartE, MdIsDivE, PerfClr,
        output StallF, StallD, FlushE, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, MdBusy, StallCnt, LoadUseCnt
    );
endinterface

// File: rtl/hazard_md_busy_tracker.sv
// md_busy_tracker: IDLE/BUSY tracker for the multi-cycle multiply/divide unit.
//   clk, rst_n : clock, async active-low reset
//   md_start   : execute stage issues a mult/div this cycle
//   md_is_div  : 1 = divide, 0 = multiply
//   md_busy    : registered, high while the unit is still producing a result
// A start loads LATENCY-1, so with the start cycle itself the unit is
// accounted for exactly LATENCY cycles. Starts while busy are ignored.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    cnt_d   = md_is_div ? DIV_LOAD : MUL_LOAD;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                // Leave on the edge the count hits zero; <= also recovers a
                // zero count that should never be seen here.
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: central hazard controller for the five-stage pipeline.
//   clk, rst_n : clock, async active-low reset
//   hz         : hazard_if.slave bundle
//     in : RsD/RtD, RsE/RtE, WriteReg{E,M,W}, RegWrite{E,M,W}, MemtoReg{E,M},
//          BranchD, MdUseD, MdStartE, MdIsDivE, PerfClr
//     out: StallF/StallD/FlushE, ForwardAD/BD (ALUOutM to comparator),
//          ForwardAE/BE (execute operand select), MdBusy, StallCnt/LoadUseCnt
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall and
// load-use counters; otherwise both counter outputs are tied to zero.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  hz
);

    localparam int NUM_OPS = 2;   // operand A (Rs) and B (Rt)

    logic     md_busy;
    logic     lwstall, branchstall, mdstall, stall;
    logic     br_dep_e, br_dep_m;

    logic     [NUM_OPS-1:0][4:0] src_e;
    logic     [NUM_OPS-1:0][4:0] src_d;
    fwd_sel_e [NUM_OPS-1:0]      fwd_e;
    logic     [NUM_OPS-1:0]      fwd_d;

    md_busy_tracker #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy (
        .clk       (clk),
        .rst_n     (rst_n),
        .md_start  (hz.MdStartE),
        .md_is_div (hz.MdIsDivE),
        .md_busy   (md_busy)
    );

    // ---- forwarding --------------------------------------------------------
    assign src_e = {hz.RtE, hz.RsE};
    assign src_d = {hz.RtD, hz.RsD};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        assign fwd_e[g] = fwd_select(hz.RegWriteM, hz.WriteRegM,
                                     hz.RegWriteW, hz.WriteRegW, src_e[g]);
        // The branch comparator only sees ALUOutM; older values come from the RF.
        assign fwd_d[g] = hz.RegWriteM && reg_match(src_d[g], hz.WriteRegM);
    end

    assign hz.ForwardAE = fwd_e[0];
    assign hz.ForwardBE = fwd_e[1];
    assign hz.ForwardAD = fwd_d[0];
    assign hz.ForwardBD = fwd_d[1];

    // ---- stalls ------------------------------------------------------------
    // Load in E: its data is not ready until after M, so the consumer in D waits.
    assign lwstall = hz.MemtoRegE &&
                     (reg_match(hz.RsD, hz.RtE) || reg_match(hz.RtD, hz.RtE));

    // Branches resolve in D: an ALU result still in E, or a load still in M,
    // cannot be forwarded to the comparator in time.
    assign br_dep_e = hz.RegWriteE &&
                      (reg_match(hz.RsD, hz.WriteRegE) || reg_match(hz.RtD, hz.WriteRegE));
    assign br_dep_m = hz.MemtoRegM &&
                      (reg_match(hz.RsD, hz.WriteRegM) || reg_match(hz.RtD, hz.WriteRegM));
    assign branchstall = hz.BranchD && (br_dep_e || br_dep_m);

    // A start in E counts as busy already so the dependent op holds from cycle 0.
    assign mdstall = hz.MdUseD && (hz.MdStartE || md_busy);

    assign stall     = lwstall || branchstall || mdstall;
    assign hz.StallF = stall;
    assign hz.StallD = stall;
    assign hz.FlushE = stall;
    assign hz.MdBusy = md_busy;

    // ---- performance counters ---------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, lu_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else if (hz.PerfClr) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (lwstall && (lu_cnt_q != 32'hFFFF_FFFF))
                lu_cnt_q <= lu_cnt_q + 32'd1;
        end
    end

    assign hz.StallCnt   = stall_cnt_q;
    assign hz.LoadUseCnt = lu_cnt_q;
`else
    logic perf_clr_unused;
    assign perf_clr_unused = hz.PerfClr;
    assign hz.StallCnt     = '0;
    assign hz.LoadUseCnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed-vector bench for hazard_unit (MUL_CYCLES=4, DIV_CYCLES=32).
// Inputs are driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_hazard_unit;
    import hazard_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    hazard_if hz();

    hazard_unit #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
        hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.MemtoRegE = 0; hz.MemtoRegM = 0; hz.BranchD = 0;
        hz.MdUseD = 0; hz.MdStartE = 0; hz.MdIsDivE = 0; hz.PerfClr = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        check({tag, ".StallF"}, {31'd0, hz.StallF}, {31'd0, exp});
        check({tag, ".StallD"}, {31'd0, hz.StallD}, {31'd0, exp});
        check({tag, ".FlushE"}, {31'd0, hz.FlushE}, {31'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int s, input int l);
        check({tag, ".StallCnt"},   hz.StallCnt,   PERF ? 32'(s) : 32'd0);
        check({tag, ".LoadUseCnt"}, hz.LoadUseCnt, PERF ? 32'(l) : 32'd0);
    endtask

    // Holds MdUseD, starts an op, counts stall and busy cycles until issue.
    task automatic md_run(input string tag, input logic is_div, input int exp_stall,
                          input int exp_busy, input bool_restart);
        int stall_n = 0;
        int busy_n  = 0;
        bit done    = 0;
        hz.MdUseD = 1; hz.MdStartE = 1; hz.MdIsDivE = is_div;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (hz.StallD) stall_n++;
            else           done = 1;
            if (hz.MdBusy) busy_n++;
            tick();
            hz.MdStartE = 0;
            // A second start while busy must be ignored.
            if (bool_restart && i == 1) begin hz.MdStartE = 1; hz.MdIsDivE = 1; end
        end
        check({tag, ".done"},  {31'd0, done}, 32'd1);
        check({tag, ".stall"}, 32'(stall_n), 32'(exp_stall));
        check({tag, ".busy"},  32'(busy_n),  32'(exp_busy));
        clear_in();
    endtask

    initial begin
        clear_in();
        // ---- reset ----
        repeat (2) @(posedge clk);
        #1;
        check("rst.MdBusy", {31'd0, hz.MdBusy}, 32'd0);
        check("rst.ForwardAE", {30'd0, hz.ForwardAE}, 32'd0);
        chk_stall("rst", 1'b0);
        chk_cnt("rst", 0, 0);
        @(negedge clk); rst_n = 1;
        tick();

        // ---- execute forwarding ----
        hz.RegWriteM = 1; hz.WriteRegM = 5; hz.RsE = 5; hz.RegWriteW = 1; hz.WriteRegW = 5;
        @(negedge clk); check("fwd.mem_beats_wb", {30'd0, hz.ForwardAE}, 32'h2);
        tick(); hz.RegWriteM = 0;
        @(negedge clk); check("fwd.wb", {30'd0, hz.ForwardAE}, 32'h1);
        tick(); hz.RsE = 0; hz.WriteRegW = 0;
        @(negedge clk); check("fwd.zero", {30'd0, hz.ForwardAE}, 32'h0);
        tick(); hz.RtE = 9; hz.RegWriteM = 1; hz.WriteRegM = 9; hz.WriteRegW = 9;
        @(negedge clk); check("fwdB.mem", {30'd0, hz.ForwardBE}, 32'h2);
        check("fwdA.none", {30'd0, hz.ForwardAE}, 32'h0);
        tick(); hz.RegWriteM = 0;
        @(negedge clk); check("fwdB.wb", {30'd0, hz.ForwardBE}, 32'h1);
        chk_stall("fwd", 1'b0);

        // ---- counters cleared, then load-use ----
        tick(); clear_in(); hz.PerfClr = 1;
        tick(); clear_in(); hz.MemtoRegE = 1; hz.RtE = 7; hz.RsD = 7;
        @(negedge clk); chk_stall("lw.rs", 1'b1); chk_cnt("lw.pre", 0, 0);
        tick(); clear_in();
        @(negedge clk); chk_stall("lw.gone", 1'b0); chk_cnt("lw.post", 1, 1);
        tick(); hz.MemtoRegE = 1;
        @(negedge clk); chk_stall("lw.r0", 1'b0);
        tick(); hz.RtE = 8; hz.RtD = 8;
        @(negedge clk); chk_stall("lw.rt", 1'b1);

        // ---- branch ----
        tick(); clear_in(); hz.BranchD = 1; hz.RsD = 3; hz.RegWriteE = 1; hz.WriteRegE = 3;
        @(negedge clk); chk_stall("br.e", 1'b1); chk_cnt("br.pre", 2, 2);
        tick(); hz.RegWriteE = 0; hz.RegWriteM = 1; hz.WriteRegM = 3;
        @(negedge clk); chk_stall("br.m_alu", 1'b0);
        check("br.ForwardAD", {31'd0, hz.ForwardAD}, 32'd1);
        check("br.ForwardBD0", {31'd0, hz.ForwardBD}, 32'd0);
        chk_cnt("br.mid", 3, 2);
        tick(); hz.MemtoRegM = 1; hz.RtD = 3;
        @(negedge clk); chk_stall("br.m_load", 1'b1);
        check("br.ForwardBD1", {31'd0, hz.ForwardBD}, 32'd1);
        tick(); hz.BranchD = 0;
        @(negedge clk); chk_stall("br.nobranch", 1'b0); chk_cnt("br.post", 4, 2);

        // ---- clear wins over increment; lw + md stall counts once ----
        tick(); clear_in(); hz.MemtoRegE = 1; hz.RtE = 7; hz.RsD = 7; hz.PerfClr = 1;
        @(negedge clk); chk_stall("clr.stall", 1'b1);
        tick(); clear_in();
        @(negedge clk); chk_cnt("clr", 0, 0);
        tick(); hz.MemtoRegE = 1; hz.RtE = 7; hz.RsD = 7; hz.MdUseD = 1; hz.MdStartE = 1;
        @(negedge clk); chk_stall("both", 1'b1);
        tick(); clear_in();
        @(negedge clk); chk_cnt("both", 1, 1);
        repeat (5) tick();
        check("both.idle", {31'd0, hz.MdBusy}, 32'd0);

        // ---- mult/div tracking ----
        md_run("mul", 1'b0, 4, 3, 1'b0);
        md_run("mul_restart", 1'b0, 4, 3, 1'b1);
        md_run("div", 1'b1, 32, 31, 1'b0);

        // ---- reset mid-divide (count 10) ----
        hz.MdUseD = 1; hz.MdStartE = 1; hz.MdIsDivE = 1;
        tick(); hz.MdStartE = 0;
        repeat (21) tick();
        @(negedge clk); check("rstmid.busy_before", {31'd0, hz.MdBusy}, 32'd1);
        #2 rst_n = 0;
        #1 check("rstmid.MdBusy", {31'd0, hz.MdBusy}, 32'd0);
        chk_stall("rstmid", 1'b0);
        @(negedge clk); rst_n = 1;
        tick();
        @(negedge clk); chk_stall("rstmid.after", 1'b0);
        check("rstmid.idle", {31'd0, hz.MdBusy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Central hazard controller for the five-stage pipeline. Drives the stall and flush controls of the IF/ID and ID/EX pipeline registers, and the forwarding selects for the decode and execute operand muxes. Tracks the multi-cycle multiply/divide unit with a small state machine so dependent instructions hold in decode until the result is ready. Sits beside the datapath; inputs come from the D/E/M/W pipeline registers.

## Interface
- MUL_CYCLES, 4, multiply latency in cycles (>=2)
- DIV_CYCLES, 32, divide latency in cycles (>=2)
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- RsD, RtD  in  5  decode source registers
- RsE, RtE  in  5  execute source registers
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  stage writes register file
- MemtoRegE, MemtoRegM  in  1  stage is a load
- BranchD  in  1  decode holds a branch (compared in D)
- MdUseD  in  1  decode reads HI/LO or issues a mult/div
- MdStartE, MdIsDivE  in  1  execute starts mult/div; 1 = divide
- PerfClr  in  1  synchronous clear of performance counters
- StallF, StallD  out  1  hold PC / IF_ID register
- FlushE  out  1  clear ID/EX register
- ForwardAD, ForwardBD  out  1  forward ALUOutM to decode comparator
- ForwardAE, ForwardBE  out  2  execute operand select
- MdBusy  out  1  mult/div in progress
- StallCnt, LoadUseCnt  out  32  performance counters

## Operation
- Register $0 never matches any comparison.
- ForwardAE: FWD_MEM (2'b10) if RegWriteM & WriteRegM==RsE; else FWD_WB (2'b01) if RegWriteW & WriteRegW==RsE; else FWD_NONE. M beats W. ForwardBE same on RtE.
- ForwardAD = RegWriteM & WriteRegM==RsD; ForwardBD same on RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & ((RegWriteE & WriteRegE in {RsD,RtD}) | (MemtoRegM & WriteRegM in {RsD,RtD})).
- mdstall = MdUseD & (MdStartE | MdBusy).
- StallF = StallD = FlushE = lwstall | branchstall | mdstall.
- MD state machine, states IDLE/BUSY, down-counter of width $clog2(max(MUL_CYCLES,DIV_CYCLES)).
  - IDLE + MdStartE: load MdIsDivE ? DIV_CYCLES-1 : MUL_CYCLES-1, go BUSY.
  - BUSY: decrement each cycle; count reaching 0 returns to IDLE in the same edge.
  - MdStartE while BUSY: ignored, count unchanged.
- MdBusy = (state==BUSY), registered.

## Timing
- Forward and stall outputs combinational from inputs plus registered MdBusy; no added latency.
- MdStartE at cycle t with MUL_CYCLES=4: MdBusy high t+1..t+3, low t+4; a held MdUseD stalls t..t+3 (4 cycles) and issues at t+4.
- Reset (async assert, sync deassert assumed by clock tree): state IDLE, count 0, MdBusy 0, counters 0. Mid-operation reset aborts the mult/div tracking immediately.
- Simultaneous lwstall and mdstall: single stall; counters increment once.

## Configuration
- HAZARD_PERF_CNT_EN defined: StallCnt increments each cycle StallD=1; LoadUseCnt each cycle lwstall=1; both saturate at 32'hFFFF_FFFF; PerfClr zeroes both next edge (clear wins over increment).
- Undefined: counters not built; StallCnt and LoadUseCnt tied to 0.

## Structure
- Package hazard_pkg: fwd_sel_e (FWD_NONE, FWD_WB, FWD_MEM), md_state_e (MD_IDLE, MD_BUSY), REG_ZERO constant.
- Sub-module md_busy_tracker: the IDLE/BUSY FSM and down-counter; exports MdBusy.

## Test plan
- RegWriteM=1, WriteRegM=5, RsE=5, also RegWriteW=1, WriteRegW=5 -> ForwardAE=2'b10; drop RegWriteM -> 2'b01; RsE=0 -> 2'b00.
- MemtoRegE=1, RtE=7, RsD=7 -> StallF=StallD=FlushE=1 for one cycle; LoadUseCnt +1 with macro.
- BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> stall; next cycle same reg in M as ALU op -> no stall, ForwardAD=1.
- MdStartE=1, MdIsDivE=0, MdUseD held -> stall exactly 4 cycles, MdBusy 3 cycles; MdIsDivE=1 -> 32 stall cycles.
- rst_n low at count 10 during divide -> MdBusy=0 immediately, no stall after release.
- With HAZARD_PERF_CNT_EN, preload-by-stall to 32'hFFFF_FFFF -> holds; PerfClr with concurrent stall -> 0.
